// File: rtl/stream_arb_mux_if.sv
// Handshake and payload bundle between N upstream requesters and one downstream consumer.
// Latency: none. This is wiring only.
// Backpressure: carries in_ready per channel and out_ready from the consumer.
interface stream_arb_mux_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_IN     = 8,
  parameter int SEL_WIDTH  = $clog2(NUM_IN)
);
  logic [NUM_IN-1:0]            in_valid;
  logic [NUM_IN-1:0]            in_ready;
  logic [NUM_IN*DATA_WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]            in_last;
  logic [SEL_WIDTH-1:0]         ext_sel;
  logic                         out_valid;
  logic                         out_ready;
  logic [DATA_WIDTH-1:0]        out_data;
  logic                         out_last;
  logic [SEL_WIDTH-1:0]         out_src;

  // Requester/consumer side: drives the channels and out_ready.
  modport master (
    output in_valid, in_data, in_last, ext_sel, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_src
  );

  // Merge block side.
  modport slave (
    input  in_valid, in_data, in_last, ext_sel, out_ready,
    output in_ready, out_valid, out_data, out_last, out_src
  );
endinterface

// File: rtl/stream_arb_mux.sv
// N-input valid/ready merge with fixed, round-robin or external-select arbitration and packet lock.
// Latency: one cycle from an accepted input beat to out_valid. Throughput is one beat per cycle.
// Backpressure: the output register accepts only when it is empty or draining. There is no skid buffer.
module stream_arb_mux #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_IN     = 8,
  parameter int SEL_WIDTH  = $clog2(NUM_IN),
  parameter int MODE       = 1
) (
  input logic             clk,
  input logic             rst_n,
  stream_arb_mux_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [SEL_WIDTH-1:0]    lock_ch_q;
  logic [SEL_WIDTH-1:0]    rr_ptr_q;

  logic [SEL_WIDTH-1:0]    arb_ch;
  logic                    arb_vld;
  logic [2*NUM_IN-1:0]     rr_rot;
  int                      rr_sum;

  logic [SEL_WIDTH-1:0]    grant;
  logic                    grant_valid;
  logic                    load;
  logic                    xfer;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic                    sel_last;

  logic                    out_valid_q;
  logic [DATA_WIDTH-1:0]   out_data_q;
  logic                    out_last_q;
  logic [SEL_WIDTH-1:0]    out_src_q;

  // IDLE-state arbitration: pick one requesting channel according to MODE.
  always_comb begin
    arb_ch  = '0;
    arb_vld = 1'b0;
    rr_rot  = '0;
    rr_sum  = 0;
    if (MODE == 0) begin
      // Walk downward so the lowest requesting index is the last one written.
      for (int i = NUM_IN - 1; i >= 0; i--) begin
        if (bus.in_valid[i]) begin
          arb_ch  = SEL_WIDTH'(i);
          arb_vld = 1'b1;
        end
      end
    end else if (MODE == 1) begin
      // Rotate the request vector so bit 0 is rr_ptr, then take the nearest requester.
      rr_rot = {bus.in_valid, bus.in_valid} >> rr_ptr_q;
      for (int j = NUM_IN - 1; j >= 0; j--) begin
        if (rr_rot[j]) begin
          rr_sum  = int'(rr_ptr_q) + j;
          arb_vld = 1'b1;
        end
      end
      if (rr_sum >= NUM_IN) begin
        rr_sum = rr_sum - NUM_IN;
      end
      arb_ch = SEL_WIDTH'(rr_sum);
    end else begin
      // Only ext_sel is eligible. An out-of-range index matches no channel.
      for (int i = 0; i < NUM_IN; i++) begin
        if ((int'(bus.ext_sel) == i) && bus.in_valid[i]) begin
          arb_ch  = SEL_WIDTH'(i);
          arb_vld = 1'b1;
        end
      end
    end
  end

  // FSM outputs: grant (forced to lock_ch while LOCKED), per-channel ready and selected beat.
  always_comb begin
    grant       = arb_ch;
    grant_valid = arb_vld;
    if (state_q == LOCKED) begin
      grant       = lock_ch_q;
      grant_valid = 1'b0;
      for (int i = 0; i < NUM_IN; i++) begin
        if (lock_ch_q == SEL_WIDTH'(i)) begin
          grant_valid = bus.in_valid[i];
        end
      end
    end
    load = !out_valid_q || bus.out_ready;
    // Ready is held low while reset is asserted, so nothing looks accepted during reset.
    xfer = rst_n && load && grant_valid;
    bus.in_ready = '0;
    sel_data     = '0;
    sel_last     = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant == SEL_WIDTH'(i)) begin
        bus.in_ready[i] = xfer;
        sel_data        = bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_last        = bus.in_last[i];
      end
    end
  end

  // Next state: any non-last beat opens or continues a packet, a last beat closes it.
  always_comb begin
    state_d = state_q;
    if (xfer) begin
      state_d = sel_last ? IDLE : LOCKED;
    end
  end

  // State, lock owner and round-robin pointer. The pointer advances only at packet end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      lock_ch_q <= '0;
      rr_ptr_q  <= '0;
    end else begin
      state_q <= state_d;
      if (xfer && !sel_last && (state_q == IDLE)) begin
        lock_ch_q <= grant;
      end
      if ((MODE == 1) && xfer && sel_last) begin
        rr_ptr_q <= (grant == SEL_WIDTH'(NUM_IN - 1)) ? '0 : grant + 1'b1;
      end
    end
  end

  // Output register: load on transfer, otherwise drop valid once the consumer takes the beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_src_q   <= '0;
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      out_data_q  <= sel_data;
      out_last_q  <= sel_last;
      out_src_q   <= grant;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_src   = out_src_q;

endmodule

// File: tb/tb_stream_arb_mux.sv
// Bench for stream_arb_mux: three instances (fixed priority, round-robin, external select).
// Per-channel beat FIFOs feed the DUTs. A packet-level model is checked every negedge.
// Directed scenarios pin the model with literal expectations.
module tb_stream_arb_mux;
  localparam int DW = 32;
  localparam int NI = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  stream_arb_mux_if #(.DATA_WIDTH(DW), .NUM_IN(NI), .SEL_WIDTH(3)) b0 ();
  stream_arb_mux_if #(.DATA_WIDTH(DW), .NUM_IN(NI), .SEL_WIDTH(3)) b1 ();
  stream_arb_mux_if #(.DATA_WIDTH(DW), .NUM_IN(NI), .SEL_WIDTH(4)) b2 ();

  stream_arb_mux #(.DATA_WIDTH(DW), .NUM_IN(NI), .SEL_WIDTH(3), .MODE(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  stream_arb_mux #(.DATA_WIDTH(DW), .NUM_IN(NI), .SEL_WIDTH(3), .MODE(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  stream_arb_mux #(.DATA_WIDTH(DW), .NUM_IN(NI), .SEL_WIDTH(4), .MODE(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));

  // Drive side, indexed by instance (index == arbitration mode).
  logic [NI-1:0]    tv [3];
  logic [NI-1:0]    tl [3];
  logic [NI*DW-1:0] td [3];
  logic [2:0]       tordy;
  logic [3:0]       tes2;

  assign b0.in_valid = tv[0]; assign b0.in_last = tl[0]; assign b0.in_data = td[0];
  assign b1.in_valid = tv[1]; assign b1.in_last = tl[1]; assign b1.in_data = td[1];
  assign b2.in_valid = tv[2]; assign b2.in_last = tl[2]; assign b2.in_data = td[2];
  assign b0.out_ready = tordy[0]; assign b1.out_ready = tordy[1]; assign b2.out_ready = tordy[2];
  assign b0.ext_sel = 3'd0; assign b1.ext_sel = 3'd0; assign b2.ext_sel = tes2;

  // Observation side.
  logic [2:0]    ov;
  logic [2:0]    ol;
  logic [NI-1:0] ir [3];
  logic [DW-1:0] od [3];
  logic [3:0]    os [3];
  assign ov[0] = b0.out_valid; assign ov[1] = b1.out_valid; assign ov[2] = b2.out_valid;
  assign ol[0] = b0.out_last;  assign ol[1] = b1.out_last;  assign ol[2] = b2.out_last;
  assign ir[0] = b0.in_ready;  assign ir[1] = b1.in_ready;  assign ir[2] = b2.in_ready;
  assign od[0] = b0.out_data;  assign od[1] = b1.out_data;  assign od[2] = b2.out_data;
  assign os[0] = {1'b0, b0.out_src}; assign os[1] = {1'b0, b1.out_src}; assign os[2] = b2.out_src;

  // Per-channel source FIFOs: {last, data}.
  logic [DW:0]   mem [3][NI][16];
  int            hd  [3][NI];
  int            qt  [3][NI];
  logic [NI-1:0] fire [3];

  // Model state.
  int            e_v [3];
  int            e_l [3];
  int            e_s [3];
  logic [DW-1:0] e_d [3];
  int            lk  [3];
  int            rr  [3];

  // Log of beats the consumer accepted.
  int            lg_src [3][64];
  logic [DW-1:0] lg_dat [3][64];
  int            lg_cyc [3][64];
  int            lg_n   [3];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  task automatic chk(input string nm, input int m, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [u%0d] cyc=%0d got=%0h want=%0h", nm, m, cyc, act, exp);
    end
  endtask

  task automatic drive();
    for (int m = 0; m < 3; m++) begin
      for (int c = 0; c < NI; c++) begin
        if (hd[m][c] != qt[m][c]) begin
          tv[m][c]            = 1'b1;
          td[m][c*DW +: DW]   = mem[m][c][hd[m][c] % 16][DW-1:0];
          tl[m][c]            = mem[m][c][hd[m][c] % 16][DW];
        end else begin
          tv[m][c]            = 1'b0;
          td[m][c*DW +: DW]   = '0;
          tl[m][c]            = 1'b0;
        end
      end
    end
  endtask

  task automatic push(input int m, input int c, input logic [DW-1:0] d, input logic last);
    mem[m][c][qt[m][c] % 16] = {last, d};
    qt[m][c]++;
    drive();
  endtask

  task automatic flush();
    for (int m = 0; m < 3; m++)
      for (int c = 0; c < NI; c++)
        hd[m][c] = qt[m][c];
    drive();
  endtask

  // Advance n cycles. Inputs change 1 time unit after the rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      for (int m = 0; m < 3; m++)
        for (int c = 0; c < NI; c++)
          if (fire[m][c]) hd[m][c]++;
      drive();
    end
  endtask

  task automatic lit_log(input string nm, input int m, input int idx, input int src, input logic [DW-1:0] dat);
    chk({nm, "_src"}, m, lg_src[m][idx], src);
    chk({nm, "_dat"}, m, lg_dat[m][idx], dat);
  endtask

  // Channel the rules say is served now: the lock owner if locked, else by mode. -1 means none.
  function automatic int model_grant(input int m);
    int idx;
    if (lk[m] >= 0) return tv[m][lk[m]] ? lk[m] : -1;
    if (m == 0) begin
      for (int i = 0; i < NI; i++) if (tv[m][i]) return i;
      return -1;
    end
    if (m == 1) begin
      for (int k = 0; k < NI; k++) begin
        idx = (rr[m] + k) % NI;
        if (tv[m][idx]) return idx;
      end
      return -1;
    end
    if (int'(tes2) < NI && tv[2][tes2[2:0]]) return int'(tes2);
    return -1;
  endfunction

  // Compare process: check outputs against the model, then advance the model by one edge.
  initial begin
    int            g;
    bit            ld;
    logic [NI-1:0] er;
    for (int m = 0; m < 3; m++) begin
      fire[m] = '0; lg_n[m] = 0; lk[m] = -1; rr[m] = 0;
      e_v[m] = 0; e_l[m] = 0; e_s[m] = 0; e_d[m] = '0;
    end
    forever begin
      @(negedge clk);
      cyc++;
      for (int m = 0; m < 3; m++) begin
        if (!rst_n) begin
          e_v[m] = 0; e_l[m] = 0; e_s[m] = 0; e_d[m] = '0; lk[m] = -1; rr[m] = 0;
          fire[m] = '0;
          chk("rst_out_valid", m, ov[m], 0);
          chk("rst_out_data",  m, od[m], 0);
          chk("rst_out_last",  m, ol[m], 0);
          chk("rst_out_src",   m, os[m], 0);
          chk("rst_in_ready",  m, ir[m], 0);
        end else begin
          chk("out_valid", m, ov[m], e_v[m]);
          if (e_v[m] != 0) begin
            chk("out_data", m, od[m], e_d[m]);
            chk("out_last", m, ol[m], e_l[m]);
            chk("out_src",  m, os[m], e_s[m]);
          end
          if (ov[m] && tordy[m]) begin
            lg_src[m][lg_n[m]] = int'(os[m]);
            lg_dat[m][lg_n[m]] = od[m];
            lg_cyc[m][lg_n[m]] = cyc;
            if (lg_n[m] < 63) lg_n[m]++;
          end
          g  = model_grant(m);
          ld = (e_v[m] == 0) || tordy[m];
          er = '0;
          if (ld && g >= 0) er[g] = 1'b1;
          chk("in_ready", m, ir[m], er);
          fire[m] = ir[m] & tv[m];
          if (ld && g >= 0) begin
            e_v[m] = 1;
            e_d[m] = td[m][g*DW +: DW];
            e_l[m] = tl[m][g];
            e_s[m] = g;
            if (tl[m][g]) begin
              lk[m] = -1;
              if (m == 1) rr[m] = (g + 1) % NI;
            end else begin
              lk[m] = g;
            end
          end else if (tordy[m]) begin
            e_v[m] = 0;
          end
        end
      end
    end
  end

  // Directed scenarios.
  initial begin
    int base;
    rst_n = 1'b0;
    tordy = 3'b111;
    tes2  = 4'd0;
    for (int m = 0; m < 3; m++)
      for (int c = 0; c < NI; c++) begin
        hd[m][c] = 0; qt[m][c] = 0;
      end
    drive();

    // Reset values, with ch3 already requesting on the fixed-priority instance.
    push(0, 3, 32'hA5A5_0003, 1'b1);
    step(3);
    chk("lit_rst_valid", 0, b0.out_valid, 0);
    chk("lit_rst_ready", 0, b0.in_ready, 0);
    rst_n = 1'b1;
    step(1);
    chk("lit_first_valid", 0, b0.out_valid, 1);
    chk("lit_first_src",   0, b0.out_src, 3);
    chk("lit_first_data",  0, b0.out_data, 32'hA5A5_0003);

    // Round-robin fairness across channels 0, 2, 5 with single-beat packets.
    base = lg_n[1];
    for (int k = 0; k < 4; k++) begin
      push(1, 0, 32'h1000_0000 | k, 1'b1);
      push(1, 2, 32'h1000_0200 | k, 1'b1);
      push(1, 5, 32'h1000_0500 | k, 1'b1);
    end
    step(14);
    lit_log("rr0", 1, base + 0, 0, 32'h1000_0000);
    lit_log("rr1", 1, base + 1, 2, 32'h1000_0200);
    lit_log("rr2", 1, base + 2, 5, 32'h1000_0500);
    lit_log("rr3", 1, base + 3, 0, 32'h1000_0001);
    lit_log("rr4", 1, base + 4, 2, 32'h1000_0201);
    lit_log("rr5", 1, base + 5, 5, 32'h1000_0501);
    for (int k = 1; k < 6; k++)
      chk("rr_rate", 1, lg_cyc[1][base + k] - lg_cyc[1][base], k);

    // Packet lock: ch1 4-beat packet holds off the higher-priority ch0.
    base = lg_n[0];
    for (int k = 0; k < 4; k++) push(0, 1, 32'h1100_0000 | k, k == 3);
    step(1);
    push(0, 0, 32'h0000_00C0, 1'b1);
    push(0, 0, 32'h0000_00C1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("lit_lock_rdy0", 0, b0.in_ready[0], 0);
      chk("lit_lock_rdy1", 0, b0.in_ready[1], 1);
      step(1);
    end
    step(4);
    for (int k = 0; k < 4; k++) lit_log("lock_pkt", 0, base + k, 1, 32'h1100_0000 | k);
    lit_log("lock_after0", 0, base + 4, 0, 32'h0000_00C0);
    lit_log("lock_after1", 0, base + 5, 0, 32'h0000_00C1);

    // Backpressure: three stalled cycles, then drain with no loss or duplication.
    tordy[0] = 1'b0;
    base = lg_n[0];
    for (int k = 0; k < 3; k++) push(0, 2, 32'h2200_0000 | k, 1'b1);
    step(1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("lit_bp_valid", 0, b0.out_valid, 1);
      chk("lit_bp_data",  0, b0.out_data, 32'h2200_0000);
      chk("lit_bp_ready", 0, b0.in_ready, 0);
      step(1);
    end
    tordy[0] = 1'b1;
    step(4);
    for (int k = 0; k < 3; k++) lit_log("bp_beat", 0, base + k, 2, 32'h2200_0000 | k);
    chk("bp_count", 0, lg_n[0] - base, 3);

    // External select out of range gives no grant, then a legal select takes effect next cycle.
    tes2 = 4'd9;
    for (int c = 0; c < NI; c++) push(2, c, 32'h3300_0000 | c, 1'b1);
    step(1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("lit_sel9_valid", 2, b2.out_valid, 0);
      chk("lit_sel9_ready", 2, b2.in_ready, 0);
      step(1);
    end
    tes2 = 4'd6;
    step(1);
    chk("lit_sel6_valid", 2, b2.out_valid, 1);
    chk("lit_sel6_src",   2, b2.out_src, 6);
    chk("lit_sel6_data",  2, b2.out_data, 32'h3300_0006);
    step(1);

    // Reset in the middle of a ch4 packet. Afterwards ch0 must win immediately.
    for (int k = 0; k < 4; k++) push(0, 4, 32'h4400_0000 | k, k == 3);
    step(2);
    rst_n = 1'b0;
    flush();
    push(0, 0, 32'hC0DE_0000, 1'b1);
    push(0, 4, 32'h4400_00FF, 1'b1);
    step(2);
    chk("lit_mrst_valid", 0, b0.out_valid, 0);
    chk("lit_mrst_ready", 0, b0.in_ready, 0);
    rst_n = 1'b1;
    step(1);
    chk("lit_mrst_src0", 0, b0.out_src, 0);
    chk("lit_mrst_dat0", 0, b0.out_data, 32'hC0DE_0000);
    step(1);
    chk("lit_mrst_src4", 0, b0.out_src, 4);
    chk("lit_mrst_dat4", 0, b0.out_data, 32'h4400_00FF);
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
